// File: rtl/cam_pixel_packer.sv
// OV7670 DVP capture: synchronizes camera signals into clk, packs byte pairs into RGB565
// pixels and pushes a frame-start marker plus one frame of pixels into the camera FIFO.
module cam_pixel_packer #(
    parameter int unsigned FRAME_WIDTH  = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        fifo_full,
    input  logic        clear_errors,
    output logic [16:0] fifo_data,
    output logic        fifo_wr_en,
    output logic        frame_done,
    output logic        overflow,
    output logic        size_error
);

    localparam int unsigned PixW  = $clog2(FRAME_WIDTH + 2);
    localparam int unsigned LineW = $clog2(FRAME_HEIGHT + 1);
    localparam logic [PixW-1:0]  PixExact = PixW'(FRAME_WIDTH);
    localparam logic [PixW-1:0]  PixSat   = PixW'(FRAME_WIDTH + 1);
    localparam logic [LineW-1:0] LineLast = LineW'(FRAME_HEIGHT - 1);
    localparam logic [16:0]      Marker   = 17'h10000;

    typedef enum logic [1:0] {StIdle, StWaitVs, StActive, StDrop} state_e;

    // {pclk, vsync, href, data[7:0]} per stage
    logic [10:0] sync_q [SYNC_STAGES];
    logic        pclk_s, vsync_s, href_s;
    logic [7:0]  data_s;
    logic        pclk_prev_q, vsync_prev_q, href_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            pclk_prev_q  <= 1'b0;
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
        end else begin
            sync_q[0] <= {cam_pclk, cam_vsync, cam_href, cam_data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            pclk_prev_q  <= pclk_s;
            vsync_prev_q <= vsync_s;
            href_prev_q  <= href_s;
        end
    end

    assign {pclk_s, vsync_s, href_s, data_s} = sync_q[SYNC_STAGES-1];

    logic sample, vsync_rise, vsync_fall, href_fall, pix_strobe;
    assign sample     = pclk_s & ~pclk_prev_q;
    assign vsync_rise = vsync_s & ~vsync_prev_q;
    assign vsync_fall = ~vsync_s & vsync_prev_q;
    assign href_fall  = ~href_s & href_prev_q;

    state_e           state_q, state_d;
    logic             phase_q, phase_d;
    logic [7:0]       byte_hi_q, byte_hi_d;
    logic [PixW-1:0]  pix_cnt_q, pix_cnt_d;
    logic [LineW-1:0] line_cnt_q, line_cnt_d;
    logic [16:0]      data_q, data_d;
    logic             wr_en_q, wr_en_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
    logic             size_err_q, size_err_d;
    logic             ovf_set, size_set;

    // Second byte of a pair completes a pixel
    assign pix_strobe = sample & href_s & phase_q;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        byte_hi_d  = byte_hi_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        data_d     = data_q;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        ovf_set    = 1'b0;
        size_set   = 1'b0;

        if (!href_s) begin
            phase_d = 1'b0;
        end else if (sample) begin
            phase_d = ~phase_q;
            if (!phase_q) byte_hi_d = data_s;
        end

        unique case (state_q)
            StIdle: begin
                if (vsync_s) state_d = StWaitVs;
            end
            StWaitVs: begin
                if (vsync_fall) begin
                    if (!enable) begin
                        state_d = StIdle;
                    end else if (fifo_full) begin
                        ovf_set = 1'b1;
                        state_d = StDrop;
                    end else begin
                        wr_en_d    = 1'b1;
                        data_d     = Marker;
                        pix_cnt_d  = '0;
                        line_cnt_d = '0;
                        phase_d    = 1'b0;
                        state_d    = StActive;
                    end
                end
            end
            StActive: begin
                if (vsync_rise) begin
                    size_set = 1'b1;
                    state_d  = StWaitVs;
                end else if (href_fall) begin
                    if (pix_cnt_q != PixExact) size_set = 1'b1;
                    pix_cnt_d  = '0;
                    line_cnt_d = line_cnt_q + 1'b1;
                    if (line_cnt_q == LineLast) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else if (pix_strobe) begin
                    if (fifo_full) begin
                        ovf_set = 1'b1;
                        state_d = StDrop;
                    end else begin
                        wr_en_d = 1'b1;
                        data_d  = {1'b0, byte_hi_q, data_s};
                        if (pix_cnt_q != PixSat) pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            StDrop: begin
                if (vsync_rise) state_d = StWaitVs;
            end
            default: state_d = StIdle;
        endcase

        // Clearing wins over a same-cycle set
        overflow_d = clear_errors ? 1'b0 : (overflow_q | ovf_set);
        size_err_d = clear_errors ? 1'b0 : (size_err_q | size_set);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            phase_q    <= 1'b0;
            byte_hi_q  <= '0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            byte_hi_q  <= byte_hi_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            data_q     <= data_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            size_err_q <= size_err_d;
        end
    end

    assign fifo_data  = data_q;
    assign fifo_wr_en = wr_en_q;
    assign frame_done = done_q;
    assign overflow   = overflow_q;
    assign size_error = size_err_q;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Bench for cam_pixel_packer: drives random DVP frames and compares the FIFO word stream,
// frame_done pulses and sticky flags against expectations built from the generated bytes.
module tb_cam_pixel_packer;

    localparam int FW = 23;
    localparam int FH = 17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        cam_pclk = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        fifo_full = 1'b0;
    logic        clear_errors = 1'b0;
    logic [16:0] fifo_data;
    logic        fifo_wr_en;
    logic        frame_done;
    logic        overflow;
    logic        size_error;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];

    cam_pixel_packer #(
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .cam_pclk    (cam_pclk),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .fifo_full   (fifo_full),
        .clear_errors(clear_errors),
        .fifo_data   (fifo_data),
        .fifo_wr_en  (fifo_wr_en),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .size_error  (size_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fifo_wr_en) got_q.push_back(fifo_data);
        if (frame_done) done_cnt++;
    end

    // One pclk period = 8 clk; href/data change with the pclk falling edge
    task automatic pclk_cycle(input logic href_v, input logic [7:0] d);
        @(negedge clk);
        cam_pclk = 1'b0;
        cam_href = href_v;
        cam_data = d;
        repeat (4) @(negedge clk);
        cam_pclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Drives one frame and appends the words the FIFO should receive to exp_q.
    task automatic run_frame(input int nlines, input int short_line, input int short_len,
                             input bit en, input int full_after, input int reset_at);
        int  pix = 0;
        bit  live;
        int  n;
        logic [7:0] b0, b1;
        enable = en;
        live = en;
        @(negedge clk);
        cam_vsync = 1'b1;
        repeat (3) pclk_cycle(1'b0, 8'h00);
        cam_vsync = 1'b0;
        if (live) exp_q.push_back(17'h10000);
        repeat (2) pclk_cycle(1'b0, 8'h00);
        for (int l = 0; l < nlines; l++) begin
            n = (l == short_line) ? short_len : FW;
            for (int p = 0; p < n; p++) begin
                b0 = 8'($urandom);
                b1 = 8'($urandom);
                pclk_cycle(1'b1, b0);
                pclk_cycle(1'b1, b1);
                if (live) exp_q.push_back({1'b0, b0, b1});
                pix++;
                if (pix == full_after) begin
                    fifo_full = 1'b1;
                    live = 1'b0;
                end
                if (pix == reset_at) begin
                    @(negedge clk);
                    rst_n = 1'b0;
                    #1;
                    checks++;
                    if ({fifo_data, fifo_wr_en, frame_done, overflow, size_error} !== 21'h0) begin
                        $display("FAIL reset_outputs: got data=%h wr=%b done=%b ovf=%b serr=%b want all 0",
                                 fifo_data, fifo_wr_en, frame_done, overflow, size_error);
                        errors++;
                    end
                    repeat (3) @(negedge clk);
                    rst_n = 1'b1;
                    live = 1'b0;
                end
            end
            repeat (3) pclk_cycle(1'b0, 8'h00);
        end
        if (live && nlines == FH) exp_done++;
        repeat (10) @(negedge clk);
    endtask

    task automatic start_test();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        exp_done = 0;
        @(negedge clk);
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (fifo_data !== 17'h0) begin
            $display("FAIL reset_fifo_data: got %h want 0", fifo_data); errors++;
        end
        checks++;
        if (fifo_wr_en !== 1'b0) begin
            $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); errors++;
        end
        checks++;
        if (frame_done !== 1'b0) begin
            $display("FAIL reset_frame_done: got %b want 0", frame_done); errors++;
        end
        checks++;
        if (overflow !== 1'b0) begin
            $display("FAIL reset_overflow: got %b want 0", overflow); errors++;
        end
        checks++;
        if (size_error !== 1'b0) begin
            $display("FAIL reset_size_error: got %b want 0", size_error); errors++;
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_nominal();
        start_test();
        run_frame(FH, -1, 0, 1'b1, -1, -1);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL nominal_count: got %0d words want %0d", got_q.size(), exp_q.size());
            errors++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL nominal_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
                errors++;
                break;
            end
        end
        checks++;
        if (done_cnt != 1) begin
            $display("FAIL nominal_done: got %0d pulses want 1", done_cnt); errors++;
        end
        checks++;
        if ({overflow, size_error} !== 2'b00) begin
            $display("FAIL nominal_flags: got ovf=%b serr=%b want 0 0", overflow, size_error);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        start_test();
        run_frame(FH, -1, 0, 1'b1, -1, -1);
        run_frame(FH, -1, 0, 1'b0, -1, -1);
        enable = 1'b1;
        checks++;
        if (got_q.size() != FH * FW + 1) begin
            $display("FAIL b2b_count: got %0d words want %0d", got_q.size(), FH * FW + 1);
            errors++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL b2b_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
                errors++;
                break;
            end
        end
        checks++;
        if (done_cnt != exp_done) begin
            $display("FAIL b2b_done: got %0d pulses want %0d", done_cnt, exp_done); errors++;
        end
    endtask

    task automatic test_overflow();
        start_test();
        run_frame(FH, -1, 0, 1'b1, 100, -1);
        fifo_full = 1'b0;
        checks++;
        if (got_q.size() != 101) begin
            $display("FAIL ovf_count: got %0d words want 101", got_q.size()); errors++;
        end
        checks++;
        if (overflow !== 1'b1) begin
            $display("FAIL ovf_flag: got %b want 1", overflow); errors++;
        end
        checks++;
        if (done_cnt != 0) begin
            $display("FAIL ovf_done: got %0d pulses want 0", done_cnt); errors++;
        end
        run_frame(FH, -1, 0, 1'b1, -1, -1);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL ovf_f2_count: got %0d words want %0d", got_q.size(), exp_q.size());
            errors++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL ovf_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
                errors++;
                break;
            end
        end
        checks++;
        if (done_cnt != 1 || size_error !== 1'b0) begin
            $display("FAIL ovf_f2_done: got done=%0d serr=%b want 1 0", done_cnt, size_error);
            errors++;
        end
        @(negedge clk);
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            $display("FAIL ovf_clear: got %b want 0", overflow); errors++;
        end
    endtask

    task automatic test_short_line();
        start_test();
        run_frame(FH, 5, FW - 1, 1'b1, -1, -1);
        checks++;
        if (got_q.size() != FH * FW) begin
            $display("FAIL short_count: got %0d words want %0d", got_q.size(), FH * FW);
            errors++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL short_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
                errors++;
                break;
            end
        end
        checks++;
        if (size_error !== 1'b1) begin
            $display("FAIL short_size_error: got %b want 1", size_error); errors++;
        end
        checks++;
        if (done_cnt != 1) begin
            $display("FAIL short_done: got %0d pulses want 1", done_cnt); errors++;
        end
    endtask

    task automatic test_early_vsync();
        start_test();
        run_frame(10, -1, 0, 1'b1, -1, -1);
        checks++;
        if (done_cnt != 0) begin
            $display("FAIL early_done: got %0d pulses want 0", done_cnt); errors++;
        end
        run_frame(FH, -1, 0, 1'b1, -1, -1);
        checks++;
        if (size_error !== 1'b1) begin
            $display("FAIL early_size_error: got %b want 1", size_error); errors++;
        end
        checks++;
        if (got_q.size() != 10 * FW + 1 + FH * FW + 1) begin
            $display("FAIL early_count: got %0d words want %0d", got_q.size(),
                     10 * FW + 1 + FH * FW + 1);
            errors++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL early_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
                errors++;
                break;
            end
        end
        checks++;
        if (done_cnt != 1) begin
            $display("FAIL early_done_total: got %0d pulses want 1", done_cnt); errors++;
        end
    endtask

    task automatic test_reset_mid_frame();
        start_test();
        run_frame(FH, -1, 0, 1'b1, -1, 200);
        checks++;
        if (got_q.size() != 201) begin
            $display("FAIL rst_partial_count: got %0d words want 201", got_q.size()); errors++;
        end
        run_frame(FH, -1, 0, 1'b1, -1, -1);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL rst_count: got %0d words want %0d", got_q.size(), exp_q.size());
            errors++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL rst_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
                errors++;
                break;
            end
        end
        checks++;
        if (done_cnt != 1 || {overflow, size_error} !== 2'b00) begin
            $display("FAIL rst_done_flags: got done=%0d ovf=%b serr=%b want 1 0 0",
                     done_cnt, overflow, size_error);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_overflow();
        test_short_line();
        test_early_vsync();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
